// File: rtl/ins_check_pc_select.sv
`default_nettype none
// ============================================================================
// Module   : ins_check_pc_select
// Purpose  : Instruction-check stage and PC-source mux for the fetch path.
//            Each non-stalled cycle the fetched word is issued downstream
//            together with a 19-bit decoded control word. A control-transfer
//            instruction inserts phases-1 bubbles. On the last bubble the
//            redirect PC is selected for one cycle.
// Ports    : clock                    - system clock, rising edge
//            reset_n                  - synchronous active-low reset
//            pc_in_0 / pc_in_1        - sequential / redirect PC
//            ins_in                   - fetched instruction word
//            wait_for_next_in         - fetch stall request (freeze)
//            pc_out                   - selected PC (combinational mux)
//            ins_out                  - issued instruction, 0 = bubble
//            signal_out               - decoded control word
//            pc_choice_out            - PC source select, 1 = pc_in_1
//            cu_enable_out            - ins_out holds a real instruction
//            communication_enable_out - signal_out carries a new word
// Revision : 1.0 - initial release
// ============================================================================
module ins_check_pc_select #(
    parameter int bus_width = 32,
    parameter int phases    = 5
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic [bus_width-1:0] pc_in_0,
    input  logic [bus_width-1:0] pc_in_1,
    input  logic [bus_width-1:0] ins_in,
    input  logic                 wait_for_next_in,
    output logic [bus_width-1:0] pc_out,
    output logic [bus_width-1:0] ins_out,
    output logic [18:0]          signal_out,
    output logic                 pc_choice_out,
    output logic                 cu_enable_out,
    output logic                 communication_enable_out
);

    localparam int             c_CNT_W  = $clog2(phases) + 1;
    localparam logic [c_CNT_W-1:0] c_CNT_LOAD = c_CNT_W'(phases - 1);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);

    // Registered state
    logic [bus_width-1:0] ins_q,    ins_d;
    logic [18:0]          sig_q,    sig_d;
    logic                 choice_q, choice_d;
    logic                 cu_q,     cu_d;
    logic                 comm_q,   comm_d;
    logic [c_CNT_W-1:0]   cnt_q,    cnt_d;

    // Decode of the incoming word
    logic [5:0]  w_opcode;
    logic        w_is_ctrl;
    logic        w_is_mem;
    logic        w_is_nop;
    logic [18:0] w_decoded;

    always_comb begin
        w_opcode  = ins_in[31:26];
        w_is_ctrl = (w_opcode == 6'b000010) || (w_opcode == 6'b000011) ||
                    (w_opcode == 6'b000100) || (w_opcode == 6'b000101);
        w_is_mem  = (w_opcode[5:3] == 3'b100) || (w_opcode[5:3] == 3'b101);
        w_is_nop  = (ins_in == '0);
        w_decoded = {w_opcode, ins_in[25:21], ins_in[20:16],
                     1'b1, w_is_ctrl, w_is_mem};
    end

    // Next-state logic. Priority below reset: wait > stall > issue.
    always_comb begin
        ins_d    = ins_q;
        sig_d    = sig_q;
        choice_d = choice_q;
        cu_d     = 1'b0;
        comm_d   = 1'b0;
        cnt_d    = cnt_q;

        if (wait_for_next_in) begin
            // Freeze: hold the issued word, counter and PC select, but drop
            // the enables so downstream does not see the word twice.
        end else if (cnt_q != '0) begin
            // Bubble cycle; the redirect PC is selected on the final one.
            ins_d    = '0;
            sig_d    = '0;
            cnt_d    = cnt_q - c_CNT_ONE;
            choice_d = (cnt_q == c_CNT_ONE);
        end else if (w_is_nop) begin
            ins_d    = '0;
            sig_d    = '0;
            choice_d = 1'b0;
        end else begin
            ins_d    = ins_in;
            sig_d    = w_decoded;
            choice_d = 1'b0;
            cu_d     = 1'b1;
            comm_d   = 1'b1;
            if (w_is_ctrl) begin
                cnt_d = c_CNT_LOAD;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            ins_q    <= '0;
            sig_q    <= '0;
            choice_q <= 1'b0;
            cu_q     <= 1'b0;
            comm_q   <= 1'b0;
            cnt_q    <= '0;
        end else begin
            ins_q    <= ins_d;
            sig_q    <= sig_d;
            choice_q <= choice_d;
            cu_q     <= cu_d;
            comm_q   <= comm_d;
            cnt_q    <= cnt_d;
        end
    end

    assign pc_out                   = choice_q ? pc_in_1 : pc_in_0;
    assign ins_out                  = ins_q;
    assign signal_out               = sig_q;
    assign pc_choice_out            = choice_q;
    assign cu_enable_out            = cu_q;
    assign communication_enable_out = comm_q;

endmodule
`default_nettype wire

// File: tb/tb_ins_check_pc_select.sv
`default_nettype none
// ============================================================================
// Module   : tb_ins_check_pc_select
// Purpose  : Directed self-checking bench for ins_check_pc_select
//            (phases = 5, bus_width = 32).
// Revision : 1.0 - initial release
// ============================================================================
module tb_ins_check_pc_select;

    localparam logic [31:0] c_PC0  = 32'h0000_0010;
    localparam logic [31:0] c_PC1  = 32'h0000_0040;
    localparam logic [31:0] c_LW   = 32'h8C22_0004;
    localparam logic [31:0] c_BEQ  = 32'h1022_0003;
    localparam logic [31:0] c_ADDI = 32'h2001_0005;
    localparam logic [31:0] c_J    = 32'h0800_0010;
    localparam logic [18:0] c_SIG_LW   = {6'b100011, 5'd1, 5'd2, 3'b101};
    localparam logic [18:0] c_SIG_BEQ  = {6'b000100, 5'd1, 5'd2, 3'b110};
    localparam logic [18:0] c_SIG_ADDI = {6'b001000, 5'd0, 5'd1, 3'b100};

    logic        clock = 1'b0;
    logic        reset_n;
    logic [31:0] pc_in_0;
    logic [31:0] pc_in_1;
    logic [31:0] ins_in;
    logic        wait_for_next_in;
    logic [31:0] pc_out;
    logic [31:0] ins_out;
    logic [18:0] signal_out;
    logic        pc_choice_out;
    logic        cu_enable_out;
    logic        communication_enable_out;

    int tests_run    = 0;
    int tests_failed = 0;

    ins_check_pc_select #(.bus_width(32), .phases(5)) dut (
        .clock                    (clock),
        .reset_n                  (reset_n),
        .pc_in_0                  (pc_in_0),
        .pc_in_1                  (pc_in_1),
        .ins_in                   (ins_in),
        .wait_for_next_in         (wait_for_next_in),
        .pc_out                   (pc_out),
        .ins_out                  (ins_out),
        .signal_out               (signal_out),
        .pc_choice_out            (pc_choice_out),
        .cu_enable_out            (cu_enable_out),
        .communication_enable_out (communication_enable_out)
    );

    always #5 clock = ~clock;

    // One rising edge, then settle; inputs are changed and outputs sampled here.
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0; ins_in = 32'h0000_0001; wait_for_next_in = 1'b0;
        pc_in_0 = c_PC0; pc_in_1 = c_PC1;
        step(); step();
        tests_run++; if (ins_out !== 32'h0) begin tests_failed++; $display("FAIL reset_ins got %h exp %h", ins_out, 32'h0); end
        tests_run++; if (signal_out !== 19'h0) begin tests_failed++; $display("FAIL reset_sig got %h exp %h", signal_out, 19'h0); end
        tests_run++; if (pc_choice_out !== 1'b0) begin tests_failed++; $display("FAIL reset_choice got %b exp 0", pc_choice_out); end
        tests_run++; if (cu_enable_out !== 1'b0) begin tests_failed++; $display("FAIL reset_cu got %b exp 0", cu_enable_out); end
        tests_run++; if (communication_enable_out !== 1'b0) begin tests_failed++; $display("FAIL reset_comm got %b exp 0", communication_enable_out); end
        tests_run++; if (pc_out !== c_PC0) begin tests_failed++; $display("FAIL reset_pc got %h exp %h", pc_out, c_PC0); end
        reset_n = 1'b1;
    endtask

    task automatic test_plain_issue();
        ins_in = c_LW;
        step();
        tests_run++; if (ins_out !== c_LW) begin tests_failed++; $display("FAIL issue_ins got %h exp %h", ins_out, c_LW); end
        tests_run++; if (signal_out !== c_SIG_LW) begin tests_failed++; $display("FAIL issue_sig got %h exp %h", signal_out, c_SIG_LW); end
        tests_run++; if (cu_enable_out !== 1'b1) begin tests_failed++; $display("FAIL issue_cu got %b exp 1", cu_enable_out); end
        tests_run++; if (communication_enable_out !== 1'b1) begin tests_failed++; $display("FAIL issue_comm got %b exp 1", communication_enable_out); end
        tests_run++; if (pc_choice_out !== 1'b0) begin tests_failed++; $display("FAIL issue_choice got %b exp 0", pc_choice_out); end
        // Wait after an issue: word held, enables drop (no duplicate issue).
        wait_for_next_in = 1'b1; ins_in = c_ADDI;
        step();
        tests_run++; if (ins_out !== c_LW) begin tests_failed++; $display("FAIL hold_ins got %h exp %h", ins_out, c_LW); end
        tests_run++; if (signal_out !== c_SIG_LW) begin tests_failed++; $display("FAIL hold_sig got %h exp %h", signal_out, c_SIG_LW); end
        tests_run++; if (cu_enable_out !== 1'b0) begin tests_failed++; $display("FAIL hold_cu got %b exp 0", cu_enable_out); end
        tests_run++; if (communication_enable_out !== 1'b0) begin tests_failed++; $display("FAIL hold_comm got %b exp 0", communication_enable_out); end
        wait_for_next_in = 1'b0;
    endtask

    task automatic test_nop();
        ins_in = 32'h0;
        step();
        tests_run++; if (ins_out !== 32'h0) begin tests_failed++; $display("FAIL nop_ins got %h exp 0", ins_out); end
        tests_run++; if (signal_out !== 19'h0) begin tests_failed++; $display("FAIL nop_sig got %h exp 0", signal_out); end
        tests_run++; if ({cu_enable_out, communication_enable_out, pc_choice_out} !== 3'b000) begin tests_failed++; $display("FAIL nop_flags got %b exp 000", {cu_enable_out, communication_enable_out, pc_choice_out}); end
        // No stall follows a NOP: the very next word issues.
        ins_in = c_ADDI;
        step();
        tests_run++; if (ins_out !== c_ADDI) begin tests_failed++; $display("FAIL nop_next_ins got %h exp %h", ins_out, c_ADDI); end
        tests_run++; if (signal_out !== c_SIG_ADDI) begin tests_failed++; $display("FAIL nop_next_sig got %h exp %h", signal_out, c_SIG_ADDI); end
    endtask

    task automatic test_branch();
        ins_in = c_BEQ;
        step(); // edge N
        tests_run++; if (signal_out !== c_SIG_BEQ) begin tests_failed++; $display("FAIL br_sig got %h exp %h", signal_out, c_SIG_BEQ); end
        tests_run++; if (cu_enable_out !== 1'b1) begin tests_failed++; $display("FAIL br_cu got %b exp 1", cu_enable_out); end
        // A jump presented during the stall must be ignored.
        ins_in = c_J;
        for (int k = 1; k <= 4; k++) begin
            step(); // edge N+k
            tests_run++; if (ins_out !== 32'h0) begin tests_failed++; $display("FAIL br_bubble_ins k=%0d got %h exp 0", k, ins_out); end
            tests_run++; if ({cu_enable_out, communication_enable_out} !== 2'b00) begin tests_failed++; $display("FAIL br_bubble_en k=%0d got %b exp 00", k, {cu_enable_out, communication_enable_out}); end
            tests_run++; if (pc_choice_out !== (k == 4)) begin tests_failed++; $display("FAIL br_choice k=%0d got %b exp %b", k, pc_choice_out, (k == 4)); end
            tests_run++; if (pc_out !== ((k == 4) ? c_PC1 : c_PC0)) begin tests_failed++; $display("FAIL br_pc k=%0d got %h exp %h", k, pc_out, ((k == 4) ? c_PC1 : c_PC0)); end
        end
        ins_in = c_ADDI;
        step(); // edge N+5
        tests_run++; if (ins_out !== c_ADDI) begin tests_failed++; $display("FAIL br_target_ins got %h exp %h", ins_out, c_ADDI); end
        tests_run++; if (pc_choice_out !== 1'b0) begin tests_failed++; $display("FAIL br_target_choice got %b exp 0", pc_choice_out); end
        tests_run++; if (cu_enable_out !== 1'b1) begin tests_failed++; $display("FAIL br_target_cu got %b exp 1", cu_enable_out); end
    endtask

    task automatic test_wait_mid_stall();
        ins_in = c_BEQ;
        step();          // N
        ins_in = c_ADDI;
        step(); step();  // N+1, N+2: two bubbles done, two remain
        wait_for_next_in = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            tests_run++; if ({cu_enable_out, communication_enable_out, pc_choice_out} !== 3'b000) begin tests_failed++; $display("FAIL wait_frozen k=%0d got %b exp 000", k, {cu_enable_out, communication_enable_out, pc_choice_out}); end
            tests_run++; if (ins_out !== 32'h0) begin tests_failed++; $display("FAIL wait_ins k=%0d got %h exp 0", k, ins_out); end
        end
        wait_for_next_in = 1'b0;
        step(); // third bubble
        tests_run++; if ({ins_out == 32'h0, pc_choice_out} !== 2'b10) begin tests_failed++; $display("FAIL wait_resume_b3 got ins=%h choice=%b exp ins=0 choice=0", ins_out, pc_choice_out); end
        step(); // fourth (last) bubble
        tests_run++; if (pc_choice_out !== 1'b1) begin tests_failed++; $display("FAIL wait_resume_b4 got %b exp 1", pc_choice_out); end
        tests_run++; if (ins_out !== 32'h0) begin tests_failed++; $display("FAIL wait_resume_b4_ins got %h exp 0", ins_out); end
        // A wait while the redirect is selected keeps it selected.
        wait_for_next_in = 1'b1;
        step();
        tests_run++; if (pc_choice_out !== 1'b1) begin tests_failed++; $display("FAIL wait_choice_hold got %b exp 1", pc_choice_out); end
        tests_run++; if (pc_out !== c_PC1) begin tests_failed++; $display("FAIL wait_choice_pc got %h exp %h", pc_out, c_PC1); end
        wait_for_next_in = 1'b0;
        step();
        tests_run++; if ({ins_out, pc_choice_out, cu_enable_out} !== {c_ADDI, 1'b0, 1'b1}) begin tests_failed++; $display("FAIL wait_target got ins=%h choice=%b cu=%b exp ins=%h choice=0 cu=1", ins_out, pc_choice_out, cu_enable_out, c_ADDI); end
    endtask

    task automatic test_reset_mid_stall();
        ins_in = c_BEQ;
        step();          // N
        ins_in = 32'h0;
        step();          // N+1
        reset_n = 1'b0;
        step();          // N+2 under reset
        tests_run++; if ({ins_out, signal_out, pc_choice_out, cu_enable_out, communication_enable_out} !== 55'h0) begin tests_failed++; $display("FAIL rst_mid got ins=%h sig=%h choice=%b exp all 0", ins_out, signal_out, pc_choice_out); end
        reset_n = 1'b1; ins_in = c_ADDI;
        step();
        tests_run++; if ({ins_out, cu_enable_out, pc_choice_out} !== {c_ADDI, 1'b1, 1'b0}) begin tests_failed++; $display("FAIL rst_mid_issue got ins=%h cu=%b choice=%b exp ins=%h cu=1 choice=0", ins_out, cu_enable_out, pc_choice_out, c_ADDI); end
        ins_in = 32'h0;
        for (int k = 0; k < 4; k++) begin
            step();
            tests_run++; if (pc_choice_out !== 1'b0) begin tests_failed++; $display("FAIL rst_mid_choice k=%0d got %b exp 0", k, pc_choice_out); end
        end
    endtask

    initial begin
        test_reset();
        test_plain_issue();
        test_nop();
        test_branch();
        test_wait_mid_stall();
        test_reset_mid_stall();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
`default_nettype wire
